// File: rtl/alu_result_checker.sv
// ============================================================================
// Module      : alu_result_checker
// Description : Self-test response checker for the 4-bit, 2-bit-select ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_checker #(
  parameter int LAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [1:0]       s,
  input  logic [3:0]       dut_out,
  input  logic             dut_cout,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic [3:0]       ff_a,
  output logic [3:0]       ff_b,
  output logic [1:0]       ff_s,
  output logic [3:0]       ff_out,
  output logic             ff_cout
);

  localparam int               c_STG_W   = 16;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [4:0]         w_exp;
  logic [c_STG_W-1:0] w_stage_in;
  logic [c_STG_W-1:0] w_tail;
  logic               w_t_valid;
  logic [3:0]         w_t_a;
  logic [3:0]         w_t_b;
  logic [1:0]         w_t_s;
  logic [4:0]         w_t_exp;
  logic               w_match;

  // Expected {cout, out}; SUB carry-out of 1 means no borrow.
  always_comb begin
    w_exp = 5'd0;
    case (s)
      2'b00:   w_exp = {1'b0, a} + {1'b0, b};
      2'b01:   w_exp = {1'b0, a} + {1'b0, ~b} + 5'd1;
      2'b10:   w_exp = {1'b0, a & b};
      default: w_exp = {1'b0, a | b};
    endcase
  end

  assign w_stage_in = {in_valid, a, b, s, w_exp};

  generate
    if (LAT == 0) begin : g_lat0
      assign w_tail = w_stage_in;
    end else begin : g_pipe
      logic [c_STG_W-1:0] r_pipe [LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) begin
            r_pipe[i] <= '0;
          end
        end else begin
          r_pipe[0] <= w_stage_in;
          for (int i = 1; i < LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign w_tail = r_pipe[LAT-1];
    end
  endgenerate

  assign w_t_valid = w_tail[15];
  assign w_t_a     = w_tail[14:11];
  assign w_t_b     = w_tail[10:7];
  assign w_t_s     = w_tail[6:5];
  assign w_t_exp   = w_tail[4:0];
  assign w_match   = (dut_out == w_t_exp[3:0]) && (dut_cout == w_t_exp[4]);

  // A comparison landing on a clear cycle is dropped, not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
      ff_a       <= 4'd0;
      ff_b       <= 4'd0;
      ff_s       <= 2'd0;
      ff_out     <= 4'd0;
      ff_cout    <= 1'b0;
    end else begin
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      if (clear) begin
        pass_cnt   <= '0;
        fail_cnt   <= '0;
        err_sticky <= 1'b0;
        ff_a       <= 4'd0;
        ff_b       <= 4'd0;
        ff_s       <= 2'd0;
        ff_out     <= 4'd0;
        ff_cout    <= 1'b0;
      end else if (w_t_valid) begin
        chk_valid <= 1'b1;
        chk_pass  <= w_match;
        if (w_match) begin
          if (pass_cnt != c_CNT_MAX) begin
            pass_cnt <= pass_cnt + c_CNT_ONE;
          end
        end else begin
          if (fail_cnt != c_CNT_MAX) begin
            fail_cnt <= fail_cnt + c_CNT_ONE;
          end
          if (!err_sticky) begin
            err_sticky <= 1'b1;
            ff_a       <= w_t_a;
            ff_b       <= w_t_b;
            ff_s       <= w_t_s;
            ff_out     <= dut_out;
            ff_cout    <= dut_cout;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_checker.sv
// ============================================================================
// Module      : tb_alu_result_checker
// Description : Four checker instances (LAT 0..3) driven by shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_checker;

  localparam int NK   = 4;
  localparam int MAXC = 2048;
  localparam int LATS [NK] = '{0, 1, 2, 3};
  localparam int CWS  [NK] = '{3, 4, 16, 16};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [1:0] s = 2'd0;

  logic [3:0]  dout  [NK];
  logic        dcout [NK];
  logic        cv    [NK];
  logic        cp    [NK];
  logic        st    [NK];
  logic        ffc   [NK];
  logic [15:0] pc    [NK];
  logic [15:0] fc    [NK];
  logic [3:0]  ffa   [NK];
  logic [3:0]  ffb   [NK];
  logic [3:0]  ffo   [NK];
  logic [1:0]  ffs   [NK];

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < NK; k++) begin : g_dut
      logic [CWS[k]-1:0] w_pc;
      logic [CWS[k]-1:0] w_fc;
      alu_result_checker #(.LAT(LATS[k]), .CNT_W(CWS[k])) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .s         (s),
        .dut_out   (dout[k]),
        .dut_cout  (dcout[k]),
        .chk_valid (cv[k]),
        .chk_pass  (cp[k]),
        .pass_cnt  (w_pc),
        .fail_cnt  (w_fc),
        .err_sticky(st[k]),
        .ff_a      (ffa[k]),
        .ff_b      (ffb[k]),
        .ff_s      (ffs[k]),
        .ff_out    (ffo[k]),
        .ff_cout   (ffc[k])
      );
      assign pc[k] = 16'(w_pc);
      assign fc[k] = 16'(w_fc);
    end
  endgenerate

  // Applied-vector history, indexed by cycle number
  bit         hv     [MAXC];
  bit         hclr   [MAXC];
  bit         hfo_en [MAXC];
  bit         hfc_en [MAXC];
  bit         hfc    [MAXC];
  logic [3:0] ha     [MAXC];
  logic [3:0] hb     [MAXC];
  logic [3:0] hfo    [MAXC];
  logic [1:0] hs     [MAXC];

  int m_cv [NK];
  int m_cp [NK];
  int m_pc [NK];
  int m_fc [NK];
  int m_st [NK];
  int m_ff [NK];
  int npulse [NK];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  task automatic check(string tag, int obs, int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [4:0] alu_ref(logic [3:0] x, logic [3:0] y, logic [1:0] op);
    int r;
    case (op)
      2'd0:    r = int'(x) + int'(y);
      2'd1:    r = (int'(x) + 16 - int'(y)) % 32;
      2'd2:    r = int'(x & y);
      default: r = int'(x | y);
    endcase
    return r[4:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_cv[k] = 0; m_cp[k] = 0; m_pc[k] = 0; m_fc[k] = 0; m_st[k] = 0; m_ff[k] = 0;
    end
    for (int i = 0; i < MAXC; i++) hv[i] = 1'b0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < NK; k++) begin
      int m;
      int mx;
      logic [4:0] e;
      m  = cyc - LATS[k];
      mx = (1 << CWS[k]) - 1;
      if (hclr[cyc]) begin
        m_cv[k] = 0; m_cp[k] = 0; m_pc[k] = 0; m_fc[k] = 0; m_st[k] = 0; m_ff[k] = 0;
      end else if (m >= 0 && hv[m]) begin
        e = alu_ref(ha[m], hb[m], hs[m]);
        m_cv[k] = 1;
        m_cp[k] = ({dcout[k], dout[k]} == e) ? 1 : 0;
        if (m_cp[k] == 1) begin
          if (m_pc[k] < mx) m_pc[k]++;
        end else begin
          if (m_fc[k] < mx) m_fc[k]++;
          if (m_st[k] == 0) begin
            m_st[k] = 1;
            m_ff[k] = int'({ha[m], hb[m], hs[m], dout[k], dcout[k]});
          end
        end
      end else begin
        m_cv[k] = 0; m_cp[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NK; k++) begin
      string p;
      p = $sformatf("i%0d", k);
      check({p, ".chk_valid"}, int'(cv[k]), m_cv[k]);
      if (m_cv[k] == 1) check({p, ".chk_pass"}, int'(cp[k]), m_cp[k]);
      check({p, ".pass_cnt"}, int'(pc[k]), m_pc[k]);
      check({p, ".fail_cnt"}, int'(fc[k]), m_fc[k]);
      check({p, ".err_sticky"}, int'(st[k]), m_st[k]);
      check({p, ".ff"}, int'({ffa[k], ffb[k], ffs[k], ffo[k], ffc[k]}), m_ff[k]);
      if (cv[k]) npulse[k]++;
    end
  endtask

  // One cycle: apply inputs, let the ALU models answer, clock, then compare.
  task automatic drive(bit v, logic [3:0] ta, logic [3:0] tb, logic [1:0] ts, bit clr,
                       bit fo_en, logic [3:0] fo, bit fc_en, bit fcv);
    hv[cyc] = v; ha[cyc] = ta; hb[cyc] = tb; hs[cyc] = ts; hclr[cyc] = clr;
    hfo_en[cyc] = fo_en; hfo[cyc] = fo; hfc_en[cyc] = fc_en; hfc[cyc] = fcv;
    in_valid = v; a = ta; b = tb; s = ts; clear = clr;
    for (int k = 0; k < NK; k++) begin
      int m;
      logic [4:0] e;
      m = cyc - LATS[k];
      if (m >= 0 && hv[m]) begin
        e = alu_ref(ha[m], hb[m], hs[m]);
        dout[k]  = hfo_en[m] ? hfo[m] : e[3:0];
        dcout[k] = hfc_en[m] ? hfc[m] : e[4];
      end else begin
        dout[k]  = 4'($urandom);
        dcout[k] = 1'($urandom);
      end
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    cyc++;
  endtask

  task automatic vec(logic [3:0] ta, logic [3:0] tb, logic [1:0] ts);
    drive(1'b1, ta, tb, ts, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NK; k++) begin
      dout[k] = 4'd0; dcout[k] = 1'b0; npulse[k] = 0;
    end
    for (int i = 0; i < MAXC; i++) hclr[i] = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1 compare_all();
    @(negedge clk);
    rst = 1'b0;

    // ADD at LAT=0
    vec(4'b1001, 4'b0101, 2'b00);
    vec(4'b1100, 4'b1100, 2'b00);
    check("add pass_cnt", int'(pc[0]), 2);
    check("add fail_cnt", int'(fc[0]), 0);

    // SUB and logic ops back-to-back
    vec(4'b0011, 4'b0011, 2'b01);
    vec(4'b1001, 4'b0011, 2'b01);
    vec(4'b1111, 4'b0000, 2'b01);
    vec(4'b0100, 4'b1001, 2'b10);
    vec(4'b0101, 4'b0001, 2'b11);
    vec(4'b0000, 4'b1111, 2'b11);
    idle(4);

    // Fault injection: first failure is frozen
    drive(1'b1, 4'b1100, 4'b1100, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    drive(1'b1, 4'b0110, 4'b1000, 2'b11, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    idle(4);
    for (int k = 0; k < NK; k++) begin
      check("fault fail_cnt", int'(fc[k]), 2);
      check("fault sticky", int'(st[k]), 1);
      check("fault ff_a", int'(ffa[k]), 12);
      check("fault ff_b", int'(ffb[k]), 12);
      check("fault ff_s", int'(ffs[k]), 0);
      check("fault ff_out", int'(ffo[k]), 8);
      check("fault ff_cout", int'(ffc[k]), 0);
    end

    // Clear collides with a failing compare on the LAT=1 instance
    drive(1'b1, 4'd3, 4'd4, 2'b00, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
    drive(1'b1, 4'd2, 4'd2, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(1);
    check("clr pass_cnt", int'(pc[1]), 1);
    check("clr fail_cnt", int'(fc[1]), 0);
    check("clr sticky", int'(st[1]), 0);
    idle(4);

    // Randomized traffic with faults and occasional clears
    for (int i = 0; i < 200; i++) begin
      bit v, clr, fo_en, fc_en;
      v     = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 29) == 0);
      fo_en = ($urandom_range(0, 9) == 0);
      fc_en = ($urandom_range(0, 9) == 0);
      drive(v, 4'($urandom), 4'($urandom), 2'($urandom), clr,
            fo_en, 4'($urandom), fc_en, 1'($urandom));
    end
    idle(4);

    // Saturation of the 3-bit counters
    drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    npulse[0] = 0;
    for (int i = 0; i < 10; i++) vec(4'($urandom), 4'($urandom), 2'($urandom));
    idle(4);
    check("sat pass_cnt", int'(pc[0]), 7);
    check("sat pulses", npulse[0], 10);
    check("sat fail_cnt", int'(fc[0]), 0);

    // Asynchronous reset with vectors in flight
    for (int i = 0; i < 3; i++) vec(4'($urandom), 4'($urandom), 2'($urandom));
    in_valid = 1'b0;
    clear    = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    #2 rst = 1'b0;
    npulse[3] = 0;
    vec(4'd5, 4'd7, 2'b00);
    idle(2);
    check("rst no stale pulse", npulse[3], 0);
    idle(1);
    check("rst new vec valid", int'(cv[3]), 1);
    check("rst new vec pulses", npulse[3], 1);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_result_checker.md
# alu_result_checker

Synthesizable response checker for the 4-bit, 2-bit-select ALU. It captures each applied operand/select triple and computes the expected result and carry. After a fixed pipeline latency it compares them against the ALU's observed outputs. It accumulates pass/fail statistics and freezes the first failing vector, so on-chip or FPGA self-test can run without a simulator.

## Interface
- `LAT`, default 0: cycles between operand sample and DUT result sample. Legal range is 0..7.
- `CNT_W`, default 16: width of the pass/fail counters.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `clear`, in, 1: synchronous clear of counters, sticky flag and first-fail capture.
- `in_valid`, in, 1: `a`/`b`/`s` carry a vector applied to the DUT this cycle.
- `a`, in, 4: operand A.
- `b`, in, 4: operand B.
- `s`, in, 2: operation select.
- `dut_out`, in, 4: observed ALU result.
- `dut_cout`, in, 1: observed ALU CarryOut.
- `chk_valid`, out, 1: one-cycle pulse when a comparison completes.
- `chk_pass`, out, 1: result of that comparison; meaningful only while `chk_valid` is high.
- `pass_cnt`, out, `CNT_W`: saturating count of passing comparisons.
- `fail_cnt`, out, `CNT_W`: saturating count of failing comparisons.
- `err_sticky`, out, 1: set on the first failure; held until `clear` or `rst`.
- `ff_a`, out, 4: A of the first failing vector.
- `ff_b`, out, 4: B of the first failing vector.
- `ff_s`, out, 2: select of the first failing vector.
- `ff_out`, out, 4: `dut_out` of the first failing vector.
- `ff_cout`, out, 1: `dut_cout` of the first failing vector.

## Operation
- **Reference model.** The expected value is computed combinationally from `a`, `b`, `s` as a 5-bit sum {cout, out}:
  - `s=00`: ADD, {cout, out} = a + b.
  - `s=01`: SUB, {cout, out} = a + ~b + 1. cout=1 means no borrow.
  - `s=10`: AND, out = a & b, cout = 0.
  - `s=11`: OR, out = a | b, cout = 0.
- **Expected pipeline.** A shift pipeline of depth `LAT` carries {valid, a, b, s, exp_out, exp_cout}. It advances every cycle, independent of `in_valid`. Bubbles propagate as valid=0.
- **Compare stage.** The compare stage sees the pipeline tail, or the live inputs when `LAT`=0. When tail valid=1, at the next edge:
  - `chk_valid`←1.
  - `chk_pass`←(dut_out==exp_out && dut_cout==exp_cout).
  - On pass: `pass_cnt`++.
  - On fail: `fail_cnt`++.
- **Saturation.** Counters saturate at 2^CNT_W−1 and never wrap.
- **First-fail capture.** On a failure while `err_sticky`=0, load `ff_*` from the tail vector and the observed DUT outputs, and set `err_sticky`. Later failures do not change `ff_*`.
- **Clear.**
  - `clear`=1 zeroes `pass_cnt`, `fail_cnt`, `err_sticky` and all `ff_*` at the next edge.
  - A comparison completing in a `clear` cycle is discarded: `chk_valid`=0 at the next edge and nothing is counted or captured.
  - Pipeline contents are preserved, so comparisons from vectors issued before `clear` still complete later.
- **Back-to-back vectors.** `in_valid` may be high every cycle; throughput is one comparison per cycle.

## Timing
- **Reset values.** All outputs are 0 and all pipeline valid bits are 0 while `rst`=1. `rst` takes effect immediately, without a clock edge.
- **Latency.** A vector sampled at edge t with `in_valid`=1 is compared against `dut_out`/`dut_cout` as present at edge t+LAT. `chk_valid`, `chk_pass`, the counters and `ff_*` update at that same edge t+LAT and are visible in the cycle after.
- **LAT=0.** Inputs and DUT outputs are sampled at the same edge. There are no pipeline registers.
- **Reset mid-stream.** Vectors in flight are dropped, and no `chk_valid` is produced for them after `rst` deasserts. The first vector after deassertion follows the normal latency.
- **Saturated counter.** At max value a further event holds the value, while `chk_valid`/`chk_pass` still pulse normally.
- **Registered outputs.** All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **ADD, LAT=0, ideal DUT model.** Apply a=1001 b=0101 s=00, then a=1100 b=1100 s=00.
  - Required: two `chk_pass`=1 pulses on consecutive cycles, with expected {0,1110} and {1,1000}.
  - Required: `pass_cnt`=2, `fail_cnt`=0.
- **SUB and logic ops, LAT=2.** Apply six back-to-back vectors with the DUT model delayed 2 cycles:
  - 0011−0011 → {1,0000}
  - 1001−0011 → {1,0110}
  - 1111−0000 → {1,1111}
  - 0100&1001 → {0,0000}
  - 0101|0001 → {0,0101}
  - 0000|1111 → {0,1111}
  - Required: `chk_valid` first asserts 3 cycles after the first vector, then six consecutive passes.
- **Fault injection.** Force `dut_cout`=0 on a=1100 b=1100 s=00, then force `dut_out`=0000 on a=0110 b=1000 s=11.
  - Required: `fail_cnt`=2, `err_sticky`=1.
  - Required: `ff_a`=1100, `ff_b`=1100, `ff_s`=00, `ff_out`=1000, `ff_cout`=0.
  - Required: `ff_*` unchanged by the second failure.
- **Clear collision, LAT=1.** Assert `clear` in the same cycle a failing comparison completes.
  - Required: no `chk_valid` pulse for that comparison, all counters 0, `err_sticky`=0.
  - Required: the following in-flight vector is still checked and counted.
- **Saturation, CNT_W=3.** Issue 10 passing vectors.
  - Required: `pass_cnt` stops at 7, and `chk_valid` pulses 10 times.
- **Reset mid-operation, LAT=3.** Assert `rst` asynchronously between clock edges with 3 vectors in flight.
  - Required: all outputs go to 0 immediately.
  - Required: no `chk_valid` pulse for those vectors after release.
  - Required: a new vector is checked 4 cycles after its issue.
